// File: rtl/riscv_mini_pkg.sv
// Shared constants and types for the RISC-V-Mini front end.
package riscv_mini_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned BYTE_W  = 8;

    // opcode 11, funct3 001: no register write, result 0
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h2003;

    localparam logic [1:0] OPC_R  = 2'b00;
    localparam logic [1:0] OPC_I  = 2'b01;
    localparam logic [1:0] OPC_L  = 2'b10;
    localparam logic [1:0] OPC_SB = 2'b11;

    typedef enum logic {
        ASM_LO = 1'b0,
        ASM_HI = 1'b1
    } asm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == LVL_FULL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign rdata  = r_mem[r_rptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst && !clr) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Byte-stream to 16-bit instruction assembler feeding a small FIFO; drives NOP_WORD when empty.
// Optional issued-instruction counter enabled by defining FETCH_ICOUNT_EN.
import riscv_mini_pkg::*;

module instr_fetch_queue #(
    parameter int unsigned        DEPTH    = 4,
    parameter logic [INSTR_W-1:0] NOP_WORD = riscv_mini_pkg::NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTE_W-1:0]      byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    input  logic                   flush,
    output logic [INSTR_W-1:0]     instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   asm_half,
    output logic [7:0]             instr_count
);

    asm_state_t          r_state;
    asm_state_t          w_state_nx;
    logic [BYTE_W-1:0]   r_lo;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [INSTR_W-1:0]  w_head;

    // Bytes and pops presented during a flush are dropped
    assign w_accept = byte_valid & byte_ready & ~flush;
    assign w_push   = w_accept & (r_state == ASM_HI);
    assign w_pop    = instr_valid & instr_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ASM_LO;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = ASM_LO;
        end else if (w_accept) begin
            w_state_nx = (r_state == ASM_LO) ? ASM_HI : ASM_LO;
        end
    end

    always_comb begin
        byte_ready = 1'b1;
        asm_half   = 1'b0;
        if (r_state == ASM_HI) begin
            byte_ready = ~w_full;
            asm_half   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lo <= '0;
        end else if (w_accept && r_state == ASM_LO) begin
            r_lo <= byte_in;
        end
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (w_push),
        .wdata ({byte_in, r_lo}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (fill_level)
    );

    assign instr_valid = ~w_empty;
    assign instr       = w_empty ? NOP_WORD : w_head;

`ifdef FETCH_ICOUNT_EN
    logic [7:0] r_icount;

    always_ff @(posedge clk) begin
        if (rst)        r_icount <= '0;
        else if (w_pop) r_icount <= r_icount + 1'b1;
    end

    assign instr_count = r_icount;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH = 4).
module tb_instr_fetch_queue;

`ifdef FETCH_ICOUNT_EN
    localparam bit ICNT_EN = 1'b1;
`else
    localparam bit ICNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        flush = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [2:0]  fill_level;
    logic        asm_half;
    logic [7:0]  instr_count;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned n_pops  = 0;
    logic [15:0] exp_q[$];

    instr_fetch_queue #(
        .DEPTH    (4),
        .NOP_WORD (16'h2003)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fill_level  (fill_level),
        .asm_half    (asm_half),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 64) begin
            tick();
            n++;
        end
        if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
        else tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic pop_chk(input logic [15:0] w);
        chk("instr", 32'(instr), 32'(w));
        chk("instr_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_pops++;
    endtask

    task automatic chk_reset_state();
        chk("rst_byte_ready", 32'(byte_ready), 32'd1);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'h2003);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_asm_half", 32'(asm_half), 32'd0);
        chk("rst_icount", 32'(instr_count), 32'd0);
    endtask

    task automatic chk_icount();
        chk("icount", 32'(instr_count), ICNT_EN ? (n_pops % 256) : 32'd0);
    endtask

    initial begin
        // 1: reset, single word, pop to empty
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state();
        send_byte(8'h2D);
        chk("t1_asm_half", 32'(asm_half), 32'd1);
        chk("t1_valid_mid", 32'(instr_valid), 32'd0);
        send_byte(8'h41);
        chk("t1_instr", 32'(instr), 32'h412D);
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_fill", 32'(fill_level), 32'd1);
        pop_chk(16'h412D);
        chk("t1_empty_valid", 32'(instr_valid), 32'd0);
        chk("t1_empty_instr", 32'(instr), 32'h2003);
        chk_icount();

        // 2: fill to DEPTH, stall in HI, pop reopens a slot next cycle
        for (int unsigned k = 1; k <= 4; k++) send_word(16'(k * 16'h0101));
        chk("t2_fill_full", 32'(fill_level), 32'd4);
        send_byte(8'h05);
        chk("t2_asm_half", 32'(asm_half), 32'd1);
        chk("t2_ready_full", 32'(byte_ready), 32'd0);
        pop_chk(16'h0101);
        chk("t2_fill_after_pop", 32'(fill_level), 32'd3);
        chk("t2_ready_reopen", 32'(byte_ready), 32'd1);
        send_byte(8'h05);
        chk("t2_fill_refill", 32'(fill_level), 32'd4);
        for (int unsigned k = 2; k <= 5; k++) pop_chk(16'(k * 16'h0101));
        chk("t2_drained", 32'(instr_valid), 32'd0);

        // 3: simultaneous push and pop, then continuous traffic across wrap
        send_word(16'h1111);
        send_word(16'h2222);
        send_byte(8'h33);
        chk("t3_head", 32'(instr), 32'h1111);
        byte_in     = 8'h33;
        byte_valid  = 1'b1;
        instr_ready = 1'b1;
        tick();
        byte_valid  = 1'b0;
        instr_ready = 1'b0;
        n_pops++;
        chk("t3_fill_same", 32'(fill_level), 32'd2);
        pop_chk(16'h2222);
        pop_chk(16'h3333);
        for (int unsigned i = 0; i < 12; i++) begin
            send_word(16'hA000 + 16'(i * 16'h0111));
            exp_q.push_back(16'hA000 + 16'(i * 16'h0111));
            if (exp_q.size() >= 3) pop_chk(exp_q.pop_front());
        end
        while (exp_q.size() > 0) pop_chk(exp_q.pop_front());
        chk("t3_empty", 32'(fill_level), 32'd0);
        chk_icount();

        // 4: flush drops queue, pending low byte and the flush-cycle byte
        send_word(16'h4444);
        send_byte(8'h77);
        flush      = 1'b1;
        byte_in    = 8'h88;
        byte_valid = 1'b1;
        tick();
        flush      = 1'b0;
        byte_valid = 1'b0;
        chk("t4_fill", 32'(fill_level), 32'd0);
        chk("t4_asm_half", 32'(asm_half), 32'd0);
        chk("t4_instr", 32'(instr), 32'h2003);
        chk("t4_valid", 32'(instr_valid), 32'd0);
        send_byte(8'h99);
        send_byte(8'hAA);
        pop_chk(16'hAA99);
        chk_icount();

        // 5: reset mid-word with words queued; pop on empty is ignored
        send_word(16'h0B0A);
        send_word(16'h0D0C);
        send_word(16'h0F0E);
        send_byte(8'h55);
        chk("t5_pre_fill", 32'(fill_level), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_pops = 0;
        chk_reset_state();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t5_empty_pop_fill", 32'(fill_level), 32'd0);
        chk("t5_empty_pop_icount", 32'(instr_count), 32'd0);

        // 6: 260 pops; counter wraps when enabled, stays 0 otherwise
        for (int unsigned i = 0; i < 260; i++) begin
            send_word(16'(i));
            pop_chk(16'(i));
        end
        chk("t6_icount", 32'(instr_count), ICNT_EN ? 32'd4 : 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
